// File: rtl/spi_sb_pkg.sv
// Shared constants and FSM type for the SB_SPI system-bus byte engine.
// SB_SPI register map, SPISR bit positions and engine states.
package spi_sb_pkg;

   localparam logic [7:0] SPICR0  = 8'h08;
   localparam logic [7:0] SPICR1  = 8'h09;
   localparam logic [7:0] SPICR2  = 8'h0A;
   localparam logic [7:0] SPIBR   = 8'h0B;
   localparam logic [7:0] SPISR   = 8'h0C;
   localparam logic [7:0] SPITXDR = 8'h0D;
   localparam logic [7:0] SPIRXDR = 8'h0E;
   localparam logic [7:0] SPICSR  = 8'h0F;

   localparam int unsigned SR_TRDY = 4;
   localparam int unsigned SR_RRDY = 3;
   localparam int unsigned SR_TOE  = 2;
   localparam int unsigned SR_ROE  = 1;

   typedef enum logic [2:0] {
      INIT_CR0,
      INIT_CR1,
      INIT_CR2,
      INIT_BR,
      INIT_CSR,
      POLL,
      RD_RX,
      WR_TX
   } state_e;

   function automatic logic is_write(state_e s);
      return (s != POLL) && (s != RD_RX);
   endfunction

endpackage

// File: rtl/spi_sb_tx_fifo.sv
// Byte-wide synchronous FIFO buffering bytes bound for SPITXDR.
// Push while full is dropped; push and pop may share a cycle.
module spi_sb_tx_fifo #(
   parameter int AW = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   cnt_d;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign full_o  = cnt_q[AW];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/spi_sb_byte_engine.sv
// SB_SPI bus master: init writes, SPISR polling, RX/TX byte streams.
// Define SPI_SB_ERR_CNT_EN to add the ROE/TOE error counter port err_cnt.
module spi_sb_byte_engine
   import spi_sb_pkg::*;
#(
   parameter logic [7:0] SPICR0_VAL = 8'h00,
   parameter logic [7:0] SPICR1_VAL = 8'h80,
   parameter logic [7:0] SPICR2_VAL = 8'h01,
   parameter logic [7:0] SPIBR_VAL  = 8'h00,
   parameter int         TX_AW      = 2
) (
   input  logic       CLK,
   input  logic       RST,
   output logic       sb_stb,
   output logic       sb_rw,
   output logic [7:0] sb_adr,
   output logic [7:0] sb_dati,
   input  logic [7:0] sb_dato,
   input  logic       sb_ack,
   output logic       init_done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef SPI_SB_ERR_CNT_EN
   output logic [7:0] err_cnt,
`endif
   output logic       tx_ready
);

   state_e     state_q, state_d;
   logic       stb_q, stb_d;
   logic       rw_q, rw_c;
   logic [7:0] adr_q, adr_c;
   logic [7:0] dati_q, dati_c;
   logic       init_done_q;
   logic       rx_valid_q;
   logic [7:0] rx_data_q;
   logic       rr_pri_q;
   logic       done;
   logic       rx_ok, tx_ok;
   logic       fifo_full, fifo_empty, fifo_pop;
   logic [7:0] fifo_head;

   assign done     = stb_q & sb_ack;
   assign rx_ok    = sb_dato[SR_RRDY] & ~rx_valid_q;
   assign tx_ok    = sb_dato[SR_TRDY] & ~fifo_empty;
   assign fifo_pop = done & (state_q == WR_TX);

   spi_sb_tx_fifo #(.AW(TX_AW)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (tx_valid),
      .pop_i   (fifo_pop),
      .wdata_i (tx_data),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= INIT_CR0;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (done) begin
         unique case (state_q)
            INIT_CR0: state_d = INIT_CR1;
            INIT_CR1: state_d = INIT_CR2;
            INIT_CR2: state_d = INIT_BR;
            INIT_BR:  state_d = INIT_CSR;
            INIT_CSR: state_d = POLL;
            POLL: begin
               if (rx_ok && (!tx_ok || !rr_pri_q)) state_d = RD_RX;
               else if (tx_ok)                     state_d = WR_TX;
               else                                state_d = POLL;
            end
            RD_RX:    state_d = POLL;
            WR_TX:    state_d = POLL;
            default:  state_d = INIT_CR0;
         endcase
      end
   end

   // Each strobe ends on ack; the low cycle after it gives the required gap.
   always_comb begin
      stb_d  = stb_q ? ~sb_ack : 1'b1;
      rw_c   = is_write(state_q);
      adr_c  = SPISR;
      dati_c = 8'h00;
      unique case (state_q)
         INIT_CR0: begin adr_c = SPICR0;  dati_c = SPICR0_VAL; end
         INIT_CR1: begin adr_c = SPICR1;  dati_c = SPICR1_VAL; end
         INIT_CR2: begin adr_c = SPICR2;  dati_c = SPICR2_VAL; end
         INIT_BR:  begin adr_c = SPIBR;   dati_c = SPIBR_VAL;  end
         INIT_CSR: begin adr_c = SPICSR;  dati_c = 8'h00;      end
         POLL:     begin adr_c = SPISR;   dati_c = 8'h00;      end
         RD_RX:    begin adr_c = SPIRXDR; dati_c = 8'h00;      end
         WR_TX:    begin adr_c = SPITXDR; dati_c = fifo_head;  end
         default:  begin adr_c = SPISR;   dati_c = 8'h00;      end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stb_q  <= 1'b0;
         rw_q   <= 1'b0;
         adr_q  <= 8'h00;
         dati_q <= 8'h00;
      end else begin
         stb_q <= stb_d;
         if (!stb_q) begin
            rw_q   <= rw_c;
            adr_q  <= adr_c;
            dati_q <= dati_c;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         init_done_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rr_pri_q    <= 1'b0;
      end else begin
         if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
         if (done) begin
            unique case (state_q)
               INIT_CSR: init_done_q <= 1'b1;
               RD_RX: begin
                  rx_data_q  <= sb_dato;
                  rx_valid_q <= 1'b1;
                  rr_pri_q   <= 1'b1;
               end
               WR_TX:   rr_pri_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_SB_ERR_CNT_EN
   logic [7:0] err_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_q <= 8'h00;
      else if (done && state_q == POLL
               && (sb_dato[SR_ROE] || sb_dato[SR_TOE])
               && err_q != 8'hFF)
         err_q <= err_q + 8'h01;
   end
   assign err_cnt = err_q;
`endif

   assign sb_stb    = stb_q;
   assign sb_rw     = rw_q;
   assign sb_adr    = adr_q;
   assign sb_dati   = dati_q;
   assign init_done = init_done_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_ready  = ~fifo_full;

endmodule

// File: tb/tb_spi_sb_byte_engine.sv
// Bench for spi_sb_byte_engine: SB_SPI register model with random ack latency.
// Scoreboard queues hold expected TXDR writes and RX beats.
module tb_spi_sb_byte_engine;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       sb_stb, sb_rw;
   logic [7:0] sb_adr, sb_dati;
   logic [7:0] sb_dato = 8'h00;
   logic       sb_ack = 1'b0;
   logic       init_done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
`ifdef SPI_SB_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   spi_sb_byte_engine dut (
      .CLK       (CLK),
      .RST       (RST),
      .sb_stb    (sb_stb),
      .sb_rw     (sb_rw),
      .sb_adr    (sb_adr),
      .sb_dati   (sb_dati),
      .sb_dato   (sb_dato),
      .sb_ack    (sb_ack),
      .init_done (init_done),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
`ifdef SPI_SB_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .tx_ready  (tx_ready)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   typedef struct packed {
      logic [7:0] adr;
      logic [7:0] dat;
   } wr_vec_t;

   typedef struct packed {
      logic [7:0] rxdr;
      logic [7:0] exp;
   } rx_vec_t;

   wr_vec_t init_tbl[5];
   rx_vec_t rx_tbl[3];

   logic [7:0]  spisr_m = 8'h00;
   logic [7:0]  rxdr_m  = 8'h00;
   logic        hold_tx = 1'b0;
   logic        log_en  = 1'b0;
   int          sr_force_n = 0;
   int          sr_reads = 0;
   int          rx_reads = 0;
   int          txdr_writes = 0;
   int          rx_beats = 0;
   logic [7:0]  last_rx = 8'h00;
   logic [15:0] wlog[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  exp_rx[$];
   logic [7:0]  acc_q[$];

   // SB_SPI register model: acks each strobe after 1-3 cycles
   logic       busy = 1'b0;
   int         lat = 0;
   logic [7:0] a_adr, a_dat;

   always @(negedge CLK) begin
      if (RST) begin
         sb_ack = 1'b0;
         busy   = 1'b0;
      end else if (sb_ack) begin
         check("stb_gap", {31'd0, sb_stb}, 32'd0);
         sb_ack = 1'b0;
      end else if (sb_stb) begin
         if (!busy) begin
            busy  = 1'b1;
            lat   = $urandom_range(0, 2);
            a_adr = sb_adr;
            a_dat = sb_dati;
         end
         if (lat > 0) begin
            lat--;
         end else if (!(hold_tx && sb_rw && sb_adr == 8'h0D)) begin
            check("bus_adr_hold", {24'd0, sb_adr}, {24'd0, a_adr});
            check("bus_dat_hold", {24'd0, sb_dati}, {24'd0, a_dat});
            if (sb_rw) begin
               if (sb_adr == 8'h0D) begin
                  txdr_writes++;
                  if (log_en) acc_q.push_back(sb_adr);
                  if (exp_tx.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL tx_unexpected: got write %02h, expected none",
                              sb_dati);
                  end else begin
                     check("txdr_data", {24'd0, sb_dati},
                           {24'd0, exp_tx.pop_front()});
                  end
               end else begin
                  wlog.push_back({sb_adr, sb_dati});
               end
            end else begin
               case (sb_adr)
                  8'h0C: begin
                     sr_reads++;
                     if (sr_force_n > 0) begin
                        sb_dato = 8'h06;
                        sr_force_n--;
                     end else begin
                        sb_dato = spisr_m;
                     end
                  end
                  8'h0E: begin
                     rx_reads++;
                     sb_dato = rxdr_m;
                     exp_rx.push_back(rxdr_m);
                     if (log_en) acc_q.push_back(sb_adr);
                  end
                  default: sb_dato = 8'h00;
               endcase
            end
            sb_ack = 1'b1;
            busy   = 1'b0;
         end
      end
   end

   // RX stream monitor
   always @(negedge CLK) begin
      if (!RST && rx_valid && rx_ready) begin
         rx_beats++;
         last_rx = rx_data;
         if (exp_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got beat %02h, expected none", rx_data);
         end else begin
            check("rx_data_sb", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
         end
      end
   end

   task automatic push_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic check_init();
      int i;
      for (i = 0; i < 300 && !init_done; i++) tick();
      check("init_done_set", {31'd0, init_done}, 32'd1);
      check("init_write_cnt", wlog.size(), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < wlog.size()) begin
            check("init_adr", {24'd0, wlog[k][15:8]}, {24'd0, init_tbl[k].adr});
            check("init_dat", {24'd0, wlog[k][7:0]}, {24'd0, init_tbl[k].dat});
         end
      end
   endtask

   initial begin
      logic [7:0] txb[4];
      logic [7:0] held;
      logic       stable;
      int         b0, s0, w0, r0, i;

      init_tbl[0] = '{adr: 8'h08, dat: 8'h00};
      init_tbl[1] = '{adr: 8'h09, dat: 8'h80};
      init_tbl[2] = '{adr: 8'h0A, dat: 8'h01};
      init_tbl[3] = '{adr: 8'h0B, dat: 8'h00};
      init_tbl[4] = '{adr: 8'h0F, dat: 8'h00};
      rx_tbl[0]   = '{rxdr: 8'hA5, exp: 8'hA5};
      rx_tbl[1]   = '{rxdr: 8'h5A, exp: 8'h5A};
      rx_tbl[2]   = '{rxdr: 8'hFF, exp: 8'hFF};
      txb[0] = 8'h11;
      txb[1] = 8'h22;
      txb[2] = 8'h33;
      txb[3] = 8'h44;

      // reset state
      repeat (3) tick();
      check("rst_stb", {31'd0, sb_stb}, 32'd0);
      check("rst_rw", {31'd0, sb_rw}, 32'd0);
      check("rst_adr", {24'd0, sb_adr}, 32'd0);
      check("rst_dati", {24'd0, sb_dati}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
`ifdef SPI_SB_ERR_CNT_EN
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
      @(negedge CLK);
      RST = 1'b0;
      check_init();

      // RX vectors, one beat each, consumer ready
      for (int v = 0; v < 3; v++) begin
         spisr_m = 8'h00;
         repeat (10) tick();
         rxdr_m = rx_tbl[v].rxdr;
         b0 = rx_beats;
         spisr_m = 8'h08;
         for (i = 0; i < 100 && rx_beats == b0; i++) tick();
         spisr_m = 8'h00;
         check("rx_beat_seen", {31'd0, rx_beats > b0}, 32'd1);
         check("rx_tbl_data", {24'd0, last_rx}, {24'd0, rx_tbl[v].exp});
         s0 = sr_reads;
         repeat (10) tick();
         check("rx_poll_follows", {31'd0, sr_reads > s0}, 32'd1);
         check("rx_valid_clear", {31'd0, rx_valid}, 32'd0);
      end

      // RX back-pressure: one beat held, no further RXDR reads
      rx_ready = 1'b0;
      rxdr_m = 8'hC3;
      r0 = rx_reads;
      spisr_m = 8'h08;
      for (i = 0; i < 100 && !rx_valid; i++) tick();
      check("bp_valid", {31'd0, rx_valid}, 32'd1);
      held = rx_data;
      stable = 1'b1;
      repeat (20) begin
         tick();
         if (!rx_valid || rx_data !== held) stable = 1'b0;
      end
      check("bp_stable", {31'd0, stable}, 32'd1);
      check("bp_data", {24'd0, held}, 32'hC3);
      check("bp_one_read", rx_reads - r0, 32'd1);
      spisr_m = 8'h00;
      repeat (8) tick();
      rx_ready = 1'b1;
      repeat (5) tick();
      check("bp_released", {31'd0, rx_valid}, 32'd0);

      // TX fill to full, then drain on TRDY pulses
      w0 = txdr_writes;
      for (int k = 0; k < 4; k++) begin
         check("tx_ready_fill", {31'd0, tx_ready}, 32'd1);
         exp_tx.push_back(txb[k]);
         push_tx(txb[k]);
      end
      check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
      push_tx(8'h55);
      check("tx_full_hold", {31'd0, tx_ready}, 32'd0);
      for (i = 0; i < 400 && exp_tx.size() > 0; i++) begin
         spisr_m = ((i % 8) < 3) ? 8'h10 : 8'h00;
         tick();
      end
      check("tx_drained", exp_tx.size(), 32'd0);
      spisr_m = 8'h10;
      repeat (20) tick();
      spisr_m = 8'h00;
      repeat (5) tick();
      check("tx_write_cnt", txdr_writes - w0, 32'd4);
      check("tx_ready_empty", {31'd0, tx_ready}, 32'd1);

      // RX and TX both ready: services alternate starting with RX
      rxdr_m = 8'h3C;
      for (int k = 0; k < 3; k++) begin
         exp_tx.push_back(8'hA1 + k[7:0]);
         push_tx(8'hA1 + k[7:0]);
      end
      acc_q.delete();
      log_en = 1'b1;
      spisr_m = 8'h18;
      for (i = 0; i < 400 && exp_tx.size() > 0; i++) tick();
      spisr_m = 8'h00;
      repeat (10) tick();
      log_en = 1'b0;
      check("alt_drained", exp_tx.size(), 32'd0);
      check("alt_len_ok", {31'd0, acc_q.size() >= 6}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         if (k < acc_q.size())
            check("alt_order", {24'd0, acc_q[k]},
                  (k % 2 == 0) ? 32'h0E : 32'h0D);
      end

      // reset while a TXDR write is waiting for ack
      hold_tx = 1'b1;
      push_tx(8'h77);
      spisr_m = 8'h10;
      for (i = 0; i < 100 && !(sb_stb && sb_rw && sb_adr == 8'h0D); i++) tick();
      check("wr_tx_wait", {31'd0, sb_stb && sb_adr == 8'h0D}, 32'd1);
      repeat (3) tick();
      check("wr_tx_still", {31'd0, sb_stb}, 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("rst_mid_stb", {31'd0, sb_stb}, 32'd0);
      tick();
      check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_mid_init", {31'd0, init_done}, 32'd0);
      check("rst_mid_adr", {24'd0, sb_adr}, 32'd0);
      spisr_m = 8'h00;
      hold_tx = 1'b0;
      wlog.delete();
      w0 = txdr_writes;
      @(negedge CLK);
      RST = 1'b0;
      check_init();
      spisr_m = 8'h10;
      repeat (30) tick();
      spisr_m = 8'h00;
      repeat (5) tick();
      check("rst_fifo_flushed", txdr_writes - w0, 32'd0);

`ifdef SPI_SB_ERR_CNT_EN
      check("err_cnt_zero", {24'd0, err_cnt}, 32'd0);
      sr_force_n = 3;
      for (i = 0; i < 200 && sr_force_n > 0; i++) tick();
      repeat (5) tick();
      check("err_cnt_three", {24'd0, err_cnt}, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
